// File: rtl/pb_disp_pkg.sv
// Shared types for the packet-builder task dispatcher.
//   pb_task_t    : 96-bit build-task descriptor forwarded to a builder's config inputs
//   eng_state_e  : per-builder engine state
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit (used only with PB_DISP_TIMEOUT_EN)
package pb_disp_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef struct packed {
    logic [31:0] addr_in;
    logic [3:0]  byte_cnt;
    logic [3:0]  pkt_type;
    logic        ecc_en;
    logic        crc_en;
    logic [1:0]  ins_ecc_err;
    logic        ins_crc_err;
    logic [3:0]  ecc_val;
    logic [7:0]  crc_val;
    logic [2:0]  sop_val;
    logic [3:0]  data_sel;
    logic [31:0] addr_out;
  } pb_task_t;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_START,
    ENG_WAIT_BUSY,
    ENG_RUN,
    ENG_DONE
  } eng_state_e;

endpackage

// File: rtl/pb_disp_engine.sv
// One builder engine: latches a task, pulses start, tracks the builder's busy/irq
// and parks in DONE until the dispatcher consumes the completion.
// Optional watchdog enabled by macro PB_DISP_TIMEOUT_EN.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   accept_i         : task transfer into this engine (only honoured in IDLE)
//   task_i           : task descriptor
//   busy_i, irq_i    : builder status
//   ack_i            : completion consumed (only honoured in DONE)
//   cfg_o, start_o   : builder config and start pulse
//   idle_o, done_o   : engine is IDLE / DONE
//   timeout_o        : DONE was reached through the watchdog
module pb_disp_engine
  import pb_disp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     accept_i,
  input  pb_task_t task_i,
  input  logic     busy_i,
  input  logic     irq_i,
  input  logic     ack_i,
  output pb_task_t cfg_o,
  output logic     start_o,
  output logic     idle_o,
  output logic     done_o,
  output logic     timeout_o
);

  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("pb_disp_engine: TIMEOUT_CYCLES must lie in 16..65535");
  end

  eng_state_e state_q, state_d;
  pb_task_t   cfg_q, cfg_d;
  logic       timeout_hit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ENG_IDLE;
      // NOTE: cfg is a plain register, not a memory; it is reset so the builder sees zeros in reset.
      cfg_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cfg_q   <= cfg_d;
    end
  end

  // Next-state logic; busy/irq only matter in WAIT_BUSY and RUN.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_d = state_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      ENG_IDLE: begin
        if (accept_i) begin
          state_d = ENG_START;
          cfg_d   = task_i;
        end
      end
      ENG_START:     state_d = ENG_WAIT_BUSY;
      ENG_WAIT_BUSY: begin
        // A short job may raise irq without ever showing busy.
        if (irq_i || timeout_hit) state_d = ENG_DONE;
        else if (busy_i)          state_d = ENG_RUN;
      end
      ENG_RUN: begin
        if (irq_i || !busy_i || timeout_hit) state_d = ENG_DONE;
      end
      ENG_DONE: begin
        if (ack_i) state_d = ENG_IDLE;
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    start_o = (state_q == ENG_START);
    idle_o  = (state_q == ENG_IDLE);
    done_o  = (state_q == ENG_DONE);
    cfg_o   = cfg_q;
  end

`ifdef PB_DISP_TIMEOUT_EN
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        waiting;

  always_comb begin
    waiting     = (state_q == ENG_WAIT_BUSY) || (state_q == ENG_RUN);
    cnt_d       = waiting ? cnt_q + 16'd1 : '0;
    timeout_hit = waiting && (cnt_q == LAST_CNT);
    timeout_d   = timeout_q;
    if (state_q == ENG_IDLE) begin
      timeout_d = 1'b0;
    end else if (timeout_hit && !irq_i && (state_q == ENG_WAIT_BUSY || busy_i)) begin
      // Only flag the watchdog when it, not a normal completion, causes DONE.
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: rtl/pb_task_dispatcher.sv
// Dispatches build tasks to two packet builders and reports their completions.
// Optional per-engine watchdog enabled by macro PB_DISP_TIMEOUT_EN.
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   task_valid_i / task_ready_o   : task handshake, task_i is the descriptor
//   pbN_cfg_o, pbN_start_o        : builder config fields and start pulse
//   pbN_busy_i, pbN_irq_i         : builder status
//   done_valid_o / done_ready_i   : completion handshake
//   done_engine_o, done_timeout_o : completing engine and watchdog flag
module pb_task_dispatcher
  import pb_disp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     task_valid_i,
  output logic     task_ready_o,
  input  pb_task_t task_i,
  output pb_task_t pb0_cfg_o,
  output pb_task_t pb1_cfg_o,
  output logic     pb0_start_o,
  output logic     pb1_start_o,
  input  logic     pb0_busy_i,
  input  logic     pb1_busy_i,
  input  logic     pb0_irq_i,
  input  logic     pb1_irq_i,
  output logic     done_valid_o,
  input  logic     done_ready_i,
  output logic     done_engine_o,
  output logic     done_timeout_o
);

  logic [1:0] idle, done, start, busy, irq, accept, ack, timeout;
  pb_task_t   cfg [2];

  logic ready_en_q, ready_en_d;  // holds task_ready_o low until the first edge after reset
  logic pref_q, pref_d;          // engine that wins when both are IDLE
  logic lock_q, lock_d;          // a completion is being presented and not yet taken
  logic lock_sel_q, lock_sel_d;
  logic grant_sel, done_sel, any_accept;

  assign busy = {pb1_busy_i, pb0_busy_i};
  assign irq  = {pb1_irq_i, pb0_irq_i};

  for (genvar i = 0; i < 2; i++) begin : g_eng
    pb_disp_engine #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_engine (
      .clk       (clk),
      .reset     (reset),
      .accept_i  (accept[i]),
      .task_i    (task_i),
      .busy_i    (busy[i]),
      .irq_i     (irq[i]),
      .ack_i     (ack[i]),
      .cfg_o     (cfg[i]),
      .start_o   (start[i]),
      .idle_o    (idle[i]),
      .done_o    (done[i]),
      .timeout_o (timeout[i])
    );
  end

  assign pb0_cfg_o   = cfg[0];
  assign pb1_cfg_o   = cfg[1];
  assign pb0_start_o = start[0];
  assign pb1_start_o = start[1];

  // Round-robin task arbitration
  always_comb begin
    grant_sel    = (idle[0] && idle[1]) ? pref_q : !idle[0];
    task_ready_o = ready_en_q && (|idle);
    any_accept   = task_valid_i && task_ready_o;
    accept       = 2'b00;
    if (any_accept) accept[grant_sel] = 1'b1;
    pref_d       = any_accept ? !grant_sel : pref_q;
    ready_en_d   = 1'b1;
  end

  // Completion mux: engine 0 first, but a presented completion stays locked
  // until taken so done_* never change under a stalled handshake.
  always_comb begin
    done_sel       = lock_q ? lock_sel_q : (!done[0] && done[1]);
    done_valid_o   = |done;
    done_engine_o  = done_valid_o && done_sel;
    done_timeout_o = done_valid_o && timeout[done_sel];
    ack            = 2'b00;
    if (done_valid_o && done_ready_i) ack[done_sel] = 1'b1;
    lock_d         = done_valid_o && !done_ready_i;
    lock_sel_d     = done_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      pref_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      pref_q     <= pref_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

endmodule

// File: tb/tb_pb_task_dispatcher.sv
// Self-checking bench for pb_task_dispatcher (default build, or with PB_DISP_TIMEOUT_EN).
module tb_pb_task_dispatcher;
  import pb_disp_pkg::*;

  localparam int unsigned TB_TIMEOUT = 16;

  logic     clk;
  logic     reset;
  logic     task_valid_i;
  logic     task_ready_o;
  pb_task_t task_i;
  pb_task_t pb0_cfg_o, pb1_cfg_o;
  logic     pb0_start_o, pb1_start_o;
  logic     pb0_busy_i, pb1_busy_i, pb0_irq_i, pb1_irq_i;
  logic     done_valid_o, done_ready_i, done_engine_o, done_timeout_o;

  typedef struct packed {
    logic eng;
    logic tmo;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       mdl_pref;
  logic [1:0] mdl_idle;

  pb_task_dispatcher #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .task_valid_i  (task_valid_i),
    .task_ready_o  (task_ready_o),
    .task_i        (task_i),
    .pb0_cfg_o     (pb0_cfg_o),
    .pb1_cfg_o     (pb1_cfg_o),
    .pb0_start_o   (pb0_start_o),
    .pb1_start_o   (pb1_start_o),
    .pb0_busy_i    (pb0_busy_i),
    .pb1_busy_i    (pb1_busy_i),
    .pb0_irq_i     (pb0_irq_i),
    .pb1_irq_i     (pb1_irq_i),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .done_engine_o (done_engine_o),
    .done_timeout_o(done_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_pref = 1'b0;
    mdl_idle = 2'b11;
    sb_q.delete();
  endtask

  function automatic pb_task_t mk_task(input logic [3:0] bc, input logic [31:0] ao,
                                       input logic [31:0] ai);
    pb_task_t t;
    t          = '0;
    t.addr_in  = ai;
    t.byte_cnt = bc;
    t.pkt_type = 4'h3;
    t.ecc_en   = 1'b1;
    t.crc_val  = 8'hA5;
    t.sop_val  = 3'h5;
    t.data_sel = 4'h9;
    t.addr_out = ao;
    return t;
  endfunction

  // Offer a task for one edge; the model predicts the engine and queues the completion.
  task automatic offer(input pb_task_t t, input logic tmo);
    logic e;
    check("offer_ready", task_ready_o, 1'b1);
    e = (mdl_idle == 2'b11) ? mdl_pref : !mdl_idle[0];
    task_valid_i = 1'b1;
    task_i       = t;
    sb_q.push_back(exp_t'{eng: e, tmo: tmo});
    mdl_idle[e] = 1'b0;
    mdl_pref    = !e;
    @(negedge clk);
  endtask

  // Wait (bounded) for a completion, compare it with the queue head and take it.
  task automatic finish_done(input int budget);
    int   n;
    exp_t x;
    n = 0;
    while (done_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_arrives", done_valid_o, 1'b1);
    if (done_valid_o === 1'b1) begin
      check("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check("done_engine", done_engine_o, x.eng);
        check("done_timeout", done_timeout_o, x.tmo);
        mdl_idle[x.eng] = 1'b1;
      end
      done_ready_i = 1'b1;
      @(negedge clk);
      done_ready_i = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  pb_task_t ta, tb0, tb1, tc, td, te, tf;
  int       n;

  initial begin
    reset = 1'b0;
    task_valid_i = 1'b0;
    task_i = '0;
    pb0_busy_i = 1'b0; pb1_busy_i = 1'b0;
    pb0_irq_i = 1'b0;  pb1_irq_i = 1'b0;
    done_ready_i = 1'b0;
    model_reset();
    ta  = mk_task(4'h7, 32'h100, 32'h1000);
    tb0 = mk_task(4'h1, 32'h200, 32'h2000);
    tb1 = mk_task(4'h2, 32'h300, 32'h3000);
    tc  = mk_task(4'h3, 32'h400, 32'h4000);
    td  = mk_task(4'h4, 32'h500, 32'h5000);
    te  = mk_task(4'h5, 32'h600, 32'h6000);
    tf  = mk_task(4'h6, 32'h700, 32'h7000);

    // Reset state
    #2;
    check("rst_ready", task_ready_o, 1'b0);
    check("rst_start", {pb1_start_o, pb0_start_o}, 2'b00);
    check("rst_cfg0", pb0_cfg_o, '0);
    check("rst_cfg1", pb1_cfg_o, '0);
    check("rst_done", {done_valid_o, done_engine_o, done_timeout_o}, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    check("ready_before_edge", task_ready_o, 1'b0);
    @(negedge clk);
    check("ready_after_edge", task_ready_o, 1'b1);

    // Single task on engine 0: busy window then irq
    offer(ta, 1'b0);
    task_valid_i = 1'b0;
    task_i = '1;
    check("a_start0", pb0_start_o, 1'b1);
    check("a_start1", pb1_start_o, 1'b0);
    check("a_cfg0", pb0_cfg_o, ta);
    @(negedge clk);
    check("a_start_one_cycle", pb0_start_o, 1'b0);
    pb0_busy_i = 1'b1;
    repeat (7) @(negedge clk);
    check("a_cfg_stable", pb0_cfg_o, ta);
    check("a_no_early_done", done_valid_o, 1'b0);
    pb0_irq_i = 1'b1;
    @(negedge clk);
    pb0_irq_i = 1'b0;
    pb0_busy_i = 1'b0;
    finish_done(4);

    // Back-to-back tasks, simultaneous irqs, stalled completion
    apply_reset();
    offer(tb0, 1'b0);
    offer(tb1, 1'b0);
    task_i = tc;
    check("b_ready_full", task_ready_o, 1'b0);
    check("b_start1", pb1_start_o, 1'b1);
    check("b_cfg0", pb0_cfg_o, tb0);
    check("b_cfg1", pb1_cfg_o, tb1);
    @(negedge clk);
    pb0_irq_i = 1'b1;
    pb1_irq_i = 1'b1;
    @(negedge clk);
    pb0_irq_i = 1'b0;
    pb1_irq_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b_hold_valid", done_valid_o, 1'b1);
      check("b_hold_engine", done_engine_o, 1'b0);
      check("b_hold_ready", task_ready_o, 1'b0);
      @(negedge clk);
    end
    finish_done(2);
    check("b_no_same_cycle_accept", pb0_start_o, 1'b0);
    check("b_held_engine1", {done_valid_o, done_engine_o}, 2'b11);
    offer(tc, 1'b0);
    task_valid_i = 1'b0;
    check("c_start0", pb0_start_o, 1'b1);
    check("c_cfg0", pb0_cfg_o, tc);
    finish_done(2);
    pb0_irq_i = 1'b1;
    @(negedge clk);
    pb0_irq_i = 1'b0;
    finish_done(4);

    // Reset during RUN: job dropped, pointer back to engine 0
    offer(td, 1'b0);
    task_valid_i = 1'b0;
    pb1_busy_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("r_ready", task_ready_o, 1'b0);
    check("r_start", {pb1_start_o, pb0_start_o}, 2'b00);
    check("r_cfg1", pb1_cfg_o, '0);
    check("r_done", {done_valid_o, done_engine_o, done_timeout_o}, 3'b000);
    model_reset();
    pb1_irq_i = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("r_no_done_after", done_valid_o, 1'b0);
    end
    pb1_irq_i = 1'b0;
    pb1_busy_i = 1'b0;
    offer(te, 1'b0);
    task_valid_i = 1'b0;
    check("r_next_engine0", {pb1_start_o, pb0_start_o}, 2'b01);
    @(negedge clk);
    pb0_busy_i = 1'b1;
    @(negedge clk);
    pb0_busy_i = 1'b0;
    finish_done(4);

`ifdef PB_DISP_TIMEOUT_EN
    // Busy never rises: watchdog fires after TB_TIMEOUT cycles in WAIT_BUSY
    offer(tf, 1'b1);
    task_valid_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (done_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t_wait_cycles", n, TB_TIMEOUT);
    finish_done(1);
`else
    // No watchdog: engine waits indefinitely
    offer(tf, 1'b0);
    task_valid_i = 1'b0;
    repeat (40) @(negedge clk);
    check("t_waits_forever", done_valid_o, 1'b0);
    check("t_timeout_tied", done_timeout_o, 1'b0);
    pb1_irq_i = 1'b1;
    @(negedge clk);
    pb1_irq_i = 1'b0;
    finish_done(4);
`endif

    check("sb_drained", sb_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_task_dispatcher.md
PB_TASK_DISPATCHER -- requirements
Module: pb_task_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles, range 16..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port task_valid_i, input, 1 bit: a build task is offered.
REQ-005 SHALL have port task_ready_o, output, 1 bit: a task is accepted this cycle.
REQ-006 SHALL have port task_i, input, pb_task_t (96 bits): addr_in 32, byte_cnt 4, pkt_type 4, ecc_en, crc_en, ins_ecc_err 2, ins_crc_err, ecc_val 4, crc_val 8, sop_val 3, data_sel 4, addr_out 32.
REQ-007 SHALL have ports pb0_cfg_o / pb1_cfg_o, output, pb_task_t: config fields to the pbN_*_top register inputs.
REQ-008 SHALL have ports pb0_start_o / pb1_start_o, output, 1 bit: start pulse to pbN_start_top.
REQ-009 SHALL have ports pb0_busy_i / pb1_busy_i and pb0_irq_i / pb1_irq_i, input, 1 bit each: builder status.
REQ-010 SHALL have ports done_valid_o, output, 1 bit, and done_ready_i, input, 1 bit: completion handshake.
REQ-011 SHALL have ports done_engine_o, output, 1 bit, and done_timeout_o, output, 1 bit: completion source and watchdog flag.

Function
REQ-012 SHALL contain one engine per builder (0, 1), each with states IDLE, START, WAIT_BUSY, RUN, DONE.
REQ-013 SHALL assert task_ready_o when at least one engine is IDLE; a task transfers on task_valid_i and task_ready_o both high.
REQ-014 SHALL select the free engine by round-robin: if both are IDLE, the engine not granted last wins; after reset engine 0 wins first.
REQ-015 SHALL, on accept, register task_i into that engine's cfg output and go IDLE to START; cfg SHALL stay stable until the engine returns to IDLE.
REQ-016 SHALL, in START, drive pbN_start_o high for exactly one cycle (the cycle after accept), then go to WAIT_BUSY.
REQ-017 SHALL go WAIT_BUSY to RUN when busy_i is high.
REQ-018 SHALL go RUN to DONE when irq_i is high, or when busy_i falls without irq.
REQ-019 SHALL go WAIT_BUSY to DONE when irq_i is high; a short job without a busy pulse is legal.
REQ-020 SHALL present each DONE engine on done_valid_o with done_engine_o; when both engines are in DONE, engine 0 SHALL be presented first and engine 1 held.
REQ-021 SHALL return the presented engine DONE to IDLE on done_ready_i high; a new task may be accepted into it in the following cycle, not the same cycle.
REQ-022 SHALL keep done_* stable while done_valid_o is high and done_ready_i is low.
REQ-023 SHALL ignore irq_i and busy_i while the engine is IDLE or DONE.

Reset
REQ-024 SHALL, on reset low, asynchronously force every engine to IDLE and set: start outputs 0, cfg outputs 0, done_valid_o 0, done_engine_o 0, done_timeout_o 0, task_ready_o 0, round-robin pointer to engine 0.
REQ-025 SHALL assert task_ready_o from the first clock edge after reset release.
REQ-026 SHALL, on reset mid-job, drop the job silently with no done report.

Configuration
REQ-027 SHALL, with macro PB_DISP_TIMEOUT_EN defined, run a 16-bit per-engine counter in WAIT_BUSY and RUN; when it reaches TIMEOUT_CYCLES the engine SHALL go to DONE with done_timeout_o 1.
REQ-028 SHALL, without PB_DISP_TIMEOUT_EN, have no counter, tie done_timeout_o to 0, and let engines wait indefinitely.

Structure
REQ-029 SHALL define pb_task_t, the engine state enum, and the default TIMEOUT_CYCLES in shared package pb_disp_pkg.
REQ-030 SHALL implement the per-builder FSM as sub-module pb_disp_engine, instantiated twice; arbitration and the done mux SHALL sit in the top.

Verification
REQ-031 Single task (byte_cnt=4'h7, addr_out=32'h100), busy high at cycles 2..10, irq at 10 -> pb0_start_o pulse 1 cycle after accept, cfg stable, done_engine_o=0, done_timeout_o=0.
REQ-032 Two back-to-back tasks -> first goes to pb0, second to pb1, task_ready_o low until one done is consumed.
REQ-033 Both irqs in the same cycle, done_ready_i held low 3 cycles -> engine 0 reported first with stable outputs, then engine 1.
REQ-034 With PB_DISP_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy never rises -> done_valid_o after 16 WAIT_BUSY cycles, done_timeout_o=1.
REQ-035 Reset asserted during RUN -> all outputs 0 immediately, no done after release, next task goes to engine 0.
